mem_line_ctrl: RTL and testbench

//  Line-granular memory controller between the cache miss/write-back path and the word-wide

---
 rtl/mem_line_if.sv | 25 ++
 rtl/mem_line_ctrl.sv | 145 ++++++++++++++
 tb/tb_mem_line_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_line_if.sv
// Requester-side handshake between a cache miss/write-back path and the line
// controller: a held line request, the line data in both directions, and gnt.
interface mem_line_if #(
  parameter int ADDR_LEN      = 11,
  parameter int LINE_ADDR_LEN = 3
);
  localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;

  logic                              rd_req;
  logic                              wr_req;
  logic [ADDR_LEN-LINE_ADDR_LEN-1:0] line_addr;
  logic [32*LINE_SIZE-1:0]           wr_line;
  logic [32*LINE_SIZE-1:0]           rd_line;
  logic                              gnt;

  modport master (
    output rd_req, wr_req, line_addr, wr_line,
    input  rd_line, gnt
  );

  modport slave (
    input  rd_req, wr_req, line_addr, wr_line,
    output rd_line, gnt
  );
endinterface

// File: rtl/mem_line_ctrl.sv
// Line-granular memory controller: waits a fixed access latency, then moves one
// cache line word by word to/from a word-wide memory with a 1-cycle registered read.
module mem_line_ctrl #(
  parameter int ADDR_LEN      = 11,
  parameter int LINE_ADDR_LEN = 3,
  parameter int WAIT_CYCLES   = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_line_if.slave           bus,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic                mem_wr_req,
  output logic [31:0]         mem_wr_data,
  input  logic [31:0]         mem_rd_data
);

  localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;
  localparam int LINE_W    = ADDR_LEN - LINE_ADDR_LEN;
  localparam int DATA_W    = 32 * LINE_SIZE;
  localparam int WAIT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  localparam logic [WAIT_W-1:0]        WAIT_LAST = WAIT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [WAIT_W-1:0]        WAIT_ONE  = WAIT_W'(1);
  localparam logic [LINE_ADDR_LEN-1:0] WORD_ZERO = '0;
  localparam logic [LINE_ADDR_LEN-1:0] WORD_ONE  = LINE_ADDR_LEN'(1);
  localparam logic [LINE_ADDR_LEN-1:0] WORD_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                   state;
  logic                     op_wr_q;
  logic [WAIT_W-1:0]        wait_cnt;
  logic [LINE_ADDR_LEN-1:0] word_cnt;
  logic                     cap_pending;
  logic [DATA_W-1:0]        rd_line_q;
  logic                     gnt_q;
  logic [LINE_W-1:0]        line_q;
  logic [DATA_W-1:0]        line_buf;

  logic                     req;
  logic                     start_xfer;
  logic                     src_wr;
  logic [LINE_W-1:0]        src_line;
  logic [31:0]              src_word0;
  logic [LINE_ADDR_LEN-1:0] next_cnt;
  logic [LINE_ADDR_LEN-1:0] cap_idx;

  assign req = bus.rd_req | bus.wr_req;

  // A transfer starts straight from IDLE when there is no wait state, so the
  // first address/data word must come from the inputs rather than the latches.
  assign start_xfer = ((state == S_IDLE) && req && (WAIT_CYCLES == 0)) ||
                      ((state == S_WAIT) && (wait_cnt == WAIT_LAST));
  assign src_wr     = (state == S_IDLE) ? bus.wr_req       : op_wr_q;
  assign src_line   = (state == S_IDLE) ? bus.line_addr    : line_q;
  assign src_word0  = (state == S_IDLE) ? bus.wr_line[31:0] : line_buf[31:0];

  // word_cnt wraps inside the line, so addresses never carry into line_q.
  assign next_cnt = word_cnt + WORD_ONE;
  assign cap_idx  = word_cnt - WORD_ONE;

  assign bus.rd_line = rd_line_q;
  assign bus.gnt     = gnt_q;

  // NOTE: pure data latches carry no reset; they are always loaded in IDLE
  // before any state reads them, and resetting them would only cost routing.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req) begin
      line_q   <= bus.line_addr;
      line_buf <= bus.wr_line;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      op_wr_q     <= 1'b0;
      wait_cnt    <= '0;
      word_cnt    <= '0;
      cap_pending <= 1'b0;
      rd_line_q   <= '0;
      gnt_q       <= 1'b0;
      mem_addr    <= '0;
      mem_wr_req  <= 1'b0;
      mem_wr_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            op_wr_q  <= bus.wr_req;
            wait_cnt <= '0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: wait_cnt <= wait_cnt + WAIT_ONE;
        S_WRITE: begin
          if (word_cnt == WORD_LAST) begin
            mem_wr_req <= 1'b0;
            word_cnt   <= '0;
            gnt_q      <= 1'b1;
            state      <= S_DONE;
          end else begin
            word_cnt    <= next_cnt;
            mem_addr    <= {line_q, next_cnt};
            mem_wr_data <= line_buf[{next_cnt, 5'd0} +: 32];
          end
        end
        S_READ: begin
          // Read data trails the address by one cycle: capture word_cnt-1.
          if (cap_pending) rd_line_q[{cap_idx, 5'd0} +: 32] <= mem_rd_data;
          if (cap_pending && word_cnt == WORD_ZERO) begin
            cap_pending <= 1'b0;
            gnt_q       <= 1'b1;
            state       <= S_DONE;
          end else begin
            cap_pending <= 1'b1;
            word_cnt    <= next_cnt;
            if (word_cnt != WORD_LAST) mem_addr <= {line_q, next_cnt};
          end
        end
        S_DONE: begin
          gnt_q <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (start_xfer) begin
        state       <= src_wr ? S_WRITE : S_READ;
        word_cnt    <= '0;
        cap_pending <= 1'b0;
        mem_addr    <= {src_line, WORD_ZERO};
        mem_wr_req  <= src_wr;
        mem_wr_data <= src_word0;
      end
    end
  end

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Scoreboard bench for mem_line_ctrl: two instances (4 wait cycles and none),
// each with its own memory, checked against a line-level model of main memory.
module tb_mem_line_ctrl;

  typedef struct {
    bit           wr;
    logic [7:0]   line;
    logic [255:0] rd_line;
    int           gnt_cyc;
    int           nwr;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  mem_line_if #(.ADDR_LEN(11), .LINE_ADDR_LEN(3)) bus_a ();
  mem_line_if #(.ADDR_LEN(11), .LINE_ADDR_LEN(3)) bus_b ();

  logic [10:0] mem_addr_a, mem_addr_b;
  logic        mem_wr_req_a, mem_wr_req_b;
  logic [31:0] mem_wr_data_a, mem_wr_data_b;
  logic [31:0] mem_rd_data_a, mem_rd_data_b;

  mem_line_ctrl #(.ADDR_LEN(11), .LINE_ADDR_LEN(3), .WAIT_CYCLES(4)) dut_a (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_a),
    .mem_addr    (mem_addr_a),
    .mem_wr_req  (mem_wr_req_a),
    .mem_wr_data (mem_wr_data_a),
    .mem_rd_data (mem_rd_data_a)
  );

  mem_line_ctrl #(.ADDR_LEN(11), .LINE_ADDR_LEN(3), .WAIT_CYCLES(0)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_b),
    .mem_addr    (mem_addr_b),
    .mem_wr_req  (mem_wr_req_b),
    .mem_wr_data (mem_wr_data_b),
    .mem_rd_data (mem_rd_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] init_word(bit sel, int i);
    if (!sel && i < 8) begin
      case (i)
        0: return 32'h5e;
        1: return 32'hb8;
        2: return 32'h51;
        3: return 32'h21;
        4: return 32'hff;
        5: return 32'h7a;
        6: return 32'h33;
        default: return 32'he4;
      endcase
    end
    return (32'(i + 1) * 32'h9E3779B9) ^ (sel ? 32'h5A5A_0000 : 32'h0000_C3C3);
  endfunction

  // Main memories seen by the two controllers: 1-cycle registered read.
  logic [31:0] ram_a [2048];
  logic [31:0] ram_b [2048];
  logic        loaded = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 2048; i++) begin
        ram_a[i] <= init_word(1'b0, i);
        ram_b[i] <= init_word(1'b1, i);
      end
      loaded <= 1'b1;
    end else begin
      if (mem_wr_req_a) ram_a[mem_addr_a] <= mem_wr_data_a;
      if (mem_wr_req_b) ram_b[mem_addr_b] <= mem_wr_data_b;
    end
    mem_rd_data_a <= ram_a[mem_addr_a];
    mem_rd_data_b <= ram_b[mem_addr_b];
  end

  // Reference model: memory contents and the line rd_line should hold.
  logic [31:0]  model_a [2048];
  logic [31:0]  model_b [2048];
  logic [255:0] last_rd_a, last_rd_b;
  exp_t         q_a[$], q_b[$];
  logic [7:0]   act_line_a, act_line_b;

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] model_line(bit sel, logic [7:0] line);
    logic [255:0] r;
    for (int i = 0; i < 8; i++)
      r[32*i +: 32] = sel ? model_b[int'(line) * 8 + i] : model_a[int'(line) * 8 + i];
    return r;
  endfunction

  task automatic model_write(bit sel, logic [7:0] line, logic [255:0] data);
    for (int i = 0; i < 8; i++) begin
      if (sel) model_b[int'(line) * 8 + i] = data[32*i +: 32];
      else     model_a[int'(line) * 8 + i] = data[32*i +: 32];
    end
  endtask

  task automatic drive(bit sel, bit wr, bit rd, logic [7:0] line, logic [255:0] data);
    if (sel) begin
      bus_b.wr_req = wr; bus_b.rd_req = rd; bus_b.line_addr = line; bus_b.wr_line = data;
    end else begin
      bus_a.wr_req = wr; bus_a.rd_req = rd; bus_a.line_addr = line; bus_a.wr_line = data;
    end
  endtask

  function automatic bit gnt_of(bit sel);
    return sel ? bus_b.gnt : bus_a.gnt;
  endfunction

  // Issues one request (called at a negedge with the DUT idle). A request with
  // both rd and wr is a write followed by a read of the same line.
  task automatic do_op(bit sel, bit wr, bit rd, logic [7:0] line, logic [255:0] data,
                       bit drop_early);
    int   w, c0, need, got;
    exp_t e;
    w    = sel ? 0 : 4;
    c0   = cyc + 1;
    need = 0;
    if (wr) begin
      e.wr = 1'b1; e.line = line; e.rd_line = sel ? last_rd_b : last_rd_a;
      e.gnt_cyc = c0 + w + 8; e.nwr = 8;
      if (sel) q_b.push_back(e); else q_a.push_back(e);
      model_write(sel, line, data);
      need++;
    end
    if (rd) begin
      if (wr) c0 = c0 + w + 10;
      e.wr = 1'b0; e.line = line; e.rd_line = model_line(sel, line);
      e.gnt_cyc = c0 + w + 9; e.nwr = 0;
      if (sel) begin q_b.push_back(e); last_rd_b = e.rd_line; end
      else     begin q_a.push_back(e); last_rd_a = e.rd_line; end
      need++;
    end
    if (sel) act_line_b = line; else act_line_a = line;
    drive(sel, wr, rd, line, data);
    if (drop_early) begin
      @(negedge clk);
      drive(sel, 1'b0, 1'b0, ~line, ~data);
    end
    got = 0;
    for (int k = 0; k < 100 && got < need; k++) begin
      @(negedge clk);
      if (gnt_of(sel)) begin
        got++;
        if (got == 1 && need == 2) drive(sel, 1'b0, 1'b1, line, data);
      end
    end
    check(sel ? "b op completes" : "a op completes", got, need);
    drive(sel, 1'b0, 1'b0, line, data);
    repeat (1 + $urandom_range(0, 2)) @(negedge clk);
  endtask

  // Monitors: compare every gnt against the scoreboard and police memory writes.
  int   wr_cnt_a, wr_cnt_b;
  exp_t mon_a, mon_b;

  always @(negedge clk) begin
    if (rst) wr_cnt_a = 0;
    else begin
      if (mem_wr_req_a) begin
        wr_cnt_a++;
        check("a write addr in line", mem_addr_a[10:3], act_line_a);
      end
      if (bus_a.gnt) begin
        check("a gnt expected", q_a.size() != 0, 1'b1);
        if (q_a.size() != 0) begin
          mon_a = q_a.pop_front();
          check("a gnt cycle", cyc, mon_a.gnt_cyc);
          check("a rd_line", bus_a.rd_line, mon_a.rd_line);
          check("a write count", wr_cnt_a, mon_a.nwr);
        end
        wr_cnt_a = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) wr_cnt_b = 0;
    else begin
      if (mem_wr_req_b) begin
        wr_cnt_b++;
        check("b write addr in line", mem_addr_b[10:3], act_line_b);
      end
      if (bus_b.gnt) begin
        check("b gnt expected", q_b.size() != 0, 1'b1);
        if (q_b.size() != 0) begin
          mon_b = q_b.pop_front();
          check("b gnt cycle", cyc, mon_b.gnt_cyc);
          check("b rd_line", bus_b.rd_line, mon_b.rd_line);
          check("b write count", wr_cnt_b, mon_b.nwr);
        end
        wr_cnt_b = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] data;
    logic [7:0]   line;
    bit           sel, wr, rd, drop;
    int           kind, pick;

    for (int i = 0; i < 2048; i++) begin
      model_a[i] = init_word(1'b0, i);
      model_b[i] = init_word(1'b1, i);
    end
    last_rd_a = '0; last_rd_b = '0;
    act_line_a = '0; act_line_b = '0;
    drive(1'b0, 1'b0, 1'b0, 8'd0, '0);
    drive(1'b1, 1'b0, 1'b0, 8'd0, '0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    check("a reset gnt", bus_a.gnt, 0);
    check("a reset mem_wr_req", mem_wr_req_a, 0);
    check("a reset mem_addr", mem_addr_a, 0);
    check("a reset mem_wr_data", mem_wr_data_a, 0);
    check("a reset rd_line", bus_a.rd_line, 0);
    check("b reset gnt", bus_b.gnt, 0);
    check("b reset mem_addr", mem_addr_b, 0);
    check("b reset rd_line", bus_b.rd_line, 0);
    rst = 1'b0;
    @(negedge clk);

    // Known image read, write/read-back, simultaneous rd+wr.
    do_op(1'b0, 1'b0, 1'b1, 8'd0, '0, 1'b0);
    for (int i = 0; i < 8; i++) data[32*i +: 32] = 32'hA5A50000 + 32'(i);
    do_op(1'b0, 1'b1, 1'b0, 8'd5, data, 1'b0);
    do_op(1'b0, 1'b0, 1'b1, 8'd5, '0, 1'b0);
    for (int i = 0; i < 8; i++) data[32*i +: 32] = $urandom;
    do_op(1'b0, 1'b1, 1'b1, 8'd2, data, 1'b0);

    // Reset while the read is presenting word 3 of line 0.
    drive(1'b0, 1'b0, 1'b1, 8'd0, '0);
    repeat (8) @(negedge clk);
    check("a mid-read addr", mem_addr_a, 11'd3);
    rst = 1'b1;
    #1;
    check("a abort gnt", bus_a.gnt, 0);
    check("a abort mem_wr_req", mem_wr_req_a, 0);
    check("a abort rd_line", bus_a.rd_line, 0);
    drive(1'b0, 1'b0, 1'b0, 8'd0, '0);
    last_rd_a = '0; last_rd_b = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op(1'b0, 1'b0, 1'b1, 8'd0, '0, 1'b0);

    // No-wait instance on the top line, then a request dropped after one cycle.
    do_op(1'b1, 1'b0, 1'b1, 8'd255, '0, 1'b0);
    for (int i = 0; i < 8; i++) data[32*i +: 32] = $urandom;
    do_op(1'b1, 1'b1, 1'b0, 8'd255, data, 1'b0);
    do_op(1'b1, 1'b0, 1'b1, 8'd255, '0, 1'b0);
    do_op(1'b0, 1'b0, 1'b1, 8'd7, '0, 1'b1);

    for (int n = 0; n < 60; n++) begin
      sel  = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 2);
      pick = $urandom_range(0, 9);
      line = (pick == 0) ? 8'd0 : (pick == 1) ? 8'd255 : 8'($urandom_range(0, 255));
      wr   = (kind != 0);
      rd   = (kind != 1);
      drop = (kind != 2) && ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 8; i++) data[32*i +: 32] = $urandom;
      do_op(sel, wr, rd, line, data, drop);
    end

    repeat (4) @(negedge clk);
    check("a queue drained", q_a.size(), 0);
    check("b queue drained", q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
